alsu_req_arbiter: RTL and testbench
===================================

// Module: alsu_req_arbiter
// PURPOSE
//  Shares one ALSU instance between two requesters. Round-robin arbitration, valid/ready
//  command handshake, single-pulse response. Drives the ALSU operand/control pins from a
//  held command register, waits out the ALSU's two-stage (input reg + output reg) latency,
//  then returns OUT/LEDS to the winner. Sits between the requesters and the ALSU.
// PARAMETERS
//  LATENCY   2   ALSU clock edges from input pins to OUT/LEDS update (input reg + output reg)
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-high
//  req0_valid     in   1   requester 0 command valid
//  req0_ready     out  1   requester 0 command accepted this cycle
//  req0_cmd       in   13  {red_b,red_a,dir,cin,opcode[2:0],b[2:0],a[2:0]}
//  req1_valid     in   1   requester 1 command valid
//  req1_ready     out  1   requester 1 command accepted this cycle
//  req1_cmd       in   13  same layout as req0_cmd
//  rsp_valid      out  1   one-cycle response pulse
//  rsp_id         out  1   requester that owns the response
//  rsp_data       out  6   ALSU OUT sampled for the command (0 on reject)
//  rsp_err        out  1   1 = ALSU LEDS nonzero at sample, or command rejected locally
//  alsu_a/alsu_b  out  3   ALSU A/B operands
//  alsu_opcode    out  3   ALSU OPCODE
//  alsu_cin, alsu_dir, alsu_red_a, alsu_red_b          out 1   ALSU controls
//  alsu_serial_in, alsu_bypass_a, alsu_bypass_b         out 1   tied 0
//  alsu_out       in   6   ALSU OUT
//  alsu_leds      in   16  ALSU LEDS
// BEHAVIOUR
//  - Reset: state=IDLE, cmd reg=0 (all alsu_* = 0), rsp_valid/rsp_id/rsp_data/rsp_err=0,
//    last_id=1 (req0 wins first tie), counter=0. Reset mid-operation aborts; no response.
//  - States: IDLE, BUSY, REJECT.
//  - IDLE: reqN_ready = valid & granted (combinational, only in IDLE). Grant: single
//    valid wins; both valid -> !last_id. Handshake edge: latch cmd, rsp_id, last_id <= id.
//  - Local reject (no ALSU issue, cmd reg unchanged): opcode >= 4 (shift/rotate depend on
//    hidden ALSU OUT state, unsafe when shared; 6/7 invalid), or (red_a|red_b) with
//    opcode >= 2. -> REJECT; next edge rsp_valid=1, rsp_err=1, rsp_data=0, -> IDLE.
//  - Accepted: alsu_* registered from cmd at handshake edge E0 -> BUSY, counter=LATENCY.
//    BUSY decrements each edge; alsu_* held stable throughout (ALSU checks some pins
//    unregistered). At edge E0+LATENCY+1: rsp_data<=alsu_out, rsp_err<=|alsu_leds,
//    rsp_valid<=1, -> IDLE. Handshake-to-rsp_valid = LATENCY+1 edges (3 by default).
//  - rsp_valid is a 1-cycle pulse, no backpressure; rsp_data/rsp_err/rsp_id hold until next
//    response. New grant allowed in the cycle rsp_valid is high (back-to-back throughput:
//    one command per LATENCY+2 cycles).
//  - IDLE keeps last issued command on alsu_* (ops 0-3 idempotent; OUT unaffected).
//  - Requester holds valid/cmd stable until ready; dropping valid before ready is allowed.
// TESTING
//  - req0 cmd a=3,b=5,op=2,cin=1 -> req0_ready 1 cycle; 3 edges later rsp_valid, id=0, data=9, err=0.
//  - req0,req1 valid together from reset -> req0 served first, then req1 (id=1); repeat -> alternates.
//  - req1 op=3,a=7,b=7 while req0 idle -> rsp id=1, data=49 (6'h31), err=0.
//  - req0 op=5 -> no alsu_* change, rsp_valid next cycle, err=1, data=0.
//  - req0 op=2 with red_a=1 -> rejected, err=1; op=0 red_a=1 a=7 -> data=1, err=0.
//  - rst pulse while BUSY -> no rsp_valid, all outputs 0, next tie grants req0.

Source files
------------

// File: rtl/alsu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alsu_req_arbiter
// Description : Two-requester round-robin front end for a single shared ALSU.
//               Accepts one command at a time over a valid/ready handshake,
//               drives the ALSU pins from a held command register, waits out
//               the ALSU pipeline latency and returns OUT/LEDS as a one-cycle
//               response pulse tagged with the owning requester.
// Revision    : 1.0  initial release
// ============================================================================
module alsu_req_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  // requester 0
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [12:0] req0_cmd,
  // requester 1
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [12:0] req1_cmd,
  // response
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [5:0]  rsp_data,
  output logic        rsp_err,
  // ALSU pins
  output logic [2:0]  alsu_a,
  output logic [2:0]  alsu_b,
  output logic [2:0]  alsu_opcode,
  output logic        alsu_cin,
  output logic        alsu_dir,
  output logic        alsu_red_a,
  output logic        alsu_red_b,
  output logic        alsu_serial_in,
  output logic        alsu_bypass_a,
  output logic        alsu_bypass_b,
  input  logic [5:0]  alsu_out,
  input  logic [15:0] alsu_leds
);

  // Counter wide enough to hold LATENCY.
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] c_CNT_LOAD = CW'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_REJECT = 2'd2
  } state_t;

  state_t        state_q,    state_d;
  logic [12:0]   cmd_q,      cmd_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          last_id_q,  last_id_d;
  logic          owner_q,    owner_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q,   rsp_id_d;
  logic [5:0]    rsp_data_q, rsp_data_d;
  logic          rsp_err_q,  rsp_err_d;

  logic          grant_any;
  logic          grant_id;
  logic [12:0]   sel_cmd;
  logic [2:0]    sel_op;
  logic          sel_red;
  logic          sel_reject;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant_any  = req0_valid | req1_valid;
    grant_id   = (req0_valid & req1_valid) ? ~last_id_q : req1_valid;
    sel_cmd    = grant_id ? req1_cmd : req0_cmd;
    sel_op     = sel_cmd[8:6];
    sel_red    = sel_cmd[11] | sel_cmd[12];
    // Shift/rotate depend on ALSU-internal OUT history, which is not safe to
    // share between requesters; 6/7 are invalid; reductions only exist for AND/XOR.
    sel_reject = (sel_op >= 3'd4) | (sel_red & (sel_op >= 3'd2));
  end

  // Ready is combinational and only asserted while idle.
  assign req0_ready = (state_q == ST_IDLE) & req0_valid & ~grant_id;
  assign req1_ready = (state_q == ST_IDLE) & req1_valid &  grant_id;

  // Next-state and datapath updates for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    last_id_d   = last_id_q;
    owner_d     = owner_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          last_id_d = grant_id;
          owner_d   = grant_id;
          if (sel_reject) begin
            // Command register left alone so the ALSU never sees the bad command.
            state_d = ST_REJECT;
          end else begin
            cmd_d   = sel_cmd;
            cnt_d   = c_CNT_LOAD;
            state_d = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          rsp_data_d  = alsu_out;
          rsp_err_d   = |alsu_leds;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_REJECT: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = owner_q;
        rsp_data_d  = 6'd0;
        rsp_err_d   = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset aborts any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      last_id_q   <= 1'b1;
      owner_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      last_id_q   <= last_id_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Command layout: {red_b, red_a, dir, cin, opcode[2:0], b[2:0], a[2:0]}
  assign alsu_a         = cmd_q[2:0];
  assign alsu_b         = cmd_q[5:3];
  assign alsu_opcode    = cmd_q[8:6];
  assign alsu_cin       = cmd_q[9];
  assign alsu_dir       = cmd_q[10];
  assign alsu_red_a     = cmd_q[11];
  assign alsu_red_b     = cmd_q[12];
  assign alsu_serial_in = 1'b0;
  assign alsu_bypass_a  = 1'b0;
  assign alsu_bypass_b  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alsu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alsu_req_arbiter
// Description : Scoreboard bench for alsu_req_arbiter with a behavioural
//               two-stage ALSU model on the pin side.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alsu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [12:0] req0_cmd = '0, req1_cmd = '0;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [5:0]  rsp_data;
  logic [2:0]  alsu_a, alsu_b, alsu_opcode;
  logic        alsu_cin, alsu_dir, alsu_red_a, alsu_red_b;
  logic        alsu_serial_in, alsu_bypass_a, alsu_bypass_b;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;

  alsu_req_arbiter #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_opcode(alsu_opcode),
    .alsu_cin(alsu_cin), .alsu_dir(alsu_dir), .alsu_red_a(alsu_red_a),
    .alsu_red_b(alsu_red_b), .alsu_serial_in(alsu_serial_in),
    .alsu_bypass_a(alsu_bypass_a), .alsu_bypass_b(alsu_bypass_b),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALSU: input register stage then output register stage.
  logic [12:0] m_in = '0;
  logic [5:0]  m_out = '0;
  logic        inject_leds = 1'b0;
  always @(posedge clk) begin
    m_in <= {alsu_red_b, alsu_red_a, alsu_dir, alsu_cin, alsu_opcode, alsu_b, alsu_a};
    case (m_in[8:6])
      3'd0: m_out <= m_in[11] ? {5'd0, &m_in[2:0]} : m_in[12] ? {5'd0, &m_in[5:3]}
                                : {3'd0, m_in[2:0] & m_in[5:3]};
      3'd1: m_out <= m_in[11] ? {5'd0, ^m_in[2:0]} : m_in[12] ? {5'd0, ^m_in[5:3]}
                                : {3'd0, m_in[2:0] ^ m_in[5:3]};
      3'd2: m_out <= 6'(m_in[2:0]) + 6'(m_in[5:3]) + 6'(m_in[9]);
      3'd3: m_out <= 6'(m_in[2:0]) * 6'(m_in[5:3]);
      default: m_out <= 6'd0;
    endcase
  end
  assign alsu_out  = m_out;
  assign alsu_leds = inject_leds ? 16'hFFFF : 16'h0000;

  typedef struct {
    logic       id;
    logic [5:0] data;
    logic       err;
    int         lat;
    int         hs;
  } exp_t;

  exp_t sb[$];
  int   acc_id[$];
  int   acc_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [5:0] exp_d0, exp_d1;
  logic       exp_e0, exp_e1;
  int         exp_l0, exp_l1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] mk(input logic rb, input logic ra, input logic dir,
                                     input logic cin, input logic [2:0] op,
                                     input logic [2:0] b, input logic [2:0] a);
    return {rb, ra, dir, cin, op, b, a};
  endfunction

  // Response monitor: pops the scoreboard whenever a response appears.
  logic prev_rsp = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("rsp_pulse", int'(prev_rsp), 0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rsp id=%0d data=%0d expected none", rsp_id, rsp_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", int'(rsp_id), int'(e.id));
          chk("rsp_data", int'(rsp_data), int'(e.data));
          chk("rsp_err", int'(rsp_err), int'(e.err));
          chk("rsp_latency", cyc - e.hs, e.lat);
        end
      end
      prev_rsp = rsp_valid;
    end
  end

  task automatic post(input bit id, input logic [12:0] c, input logic [5:0] d,
                      input logic e, input int lat);
    if (id == 1'b0) begin
      req0_cmd = c; exp_d0 = d; exp_e0 = e; exp_l0 = lat; req0_valid = 1'b1;
    end else begin
      req1_cmd = c; exp_d1 = d; exp_e1 = e; exp_l1 = lat; req1_valid = 1'b1;
    end
  endtask

  // Runs until every posted command is accepted; expectations enter the
  // scoreboard at the handshake.
  task automatic run_accept();
    int  n;
    bit  c0, c1;
    n = 0;
    while ((req0_valid || req1_valid) && n < 60) begin
      @(negedge clk);
      c0 = req0_valid && req0_ready;
      c1 = req1_valid && req1_ready;
      if (c0) begin
        sb.push_back('{1'b0, exp_d0, exp_e0, exp_l0, cyc + 1});
        acc_id.push_back(0); acc_cyc.push_back(cyc + 1);
      end
      if (c1) begin
        sb.push_back('{1'b1, exp_d1, exp_e1, exp_l1, cyc + 1});
        acc_id.push_back(1); acc_cyc.push_back(cyc + 1);
      end
      @(posedge clk); #1;
      if (c0) req0_valid = 1'b0;
      if (c1) req1_valid = 1'b0;
      n++;
    end
    if (n >= 60) begin
      chk("accept_timeout", n, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(posedge clk); n++;
    end
    if (n >= 60) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({rsp_valid, rsp_id, rsp_data, rsp_err, alsu_a, alsu_b, alsu_opcode,
                    alsu_cin, alsu_dir, alsu_red_a, alsu_red_b, alsu_serial_in,
                    alsu_bypass_a, alsu_bypass_b}), 0);
  endtask

  logic [12:0] pins_before;
  function automatic logic [12:0] pins();
    return {alsu_red_b, alsu_red_a, alsu_dir, alsu_cin, alsu_opcode, alsu_b, alsu_a};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    rst = 1'b0;
    @(posedge clk); #1;

    // Tie from reset: req0 first, then req1; second grant one full slot later.
    acc_id.delete(); acc_cyc.delete();
    post(0, mk(0,0,0,0,3'd3,3'd3,3'd2), 6'd6, 1'b0, 3);
    post(1, mk(0,0,0,0,3'd0,3'd3,3'd6), 6'd2, 1'b0, 3);
    run_accept();
    chk("tie1_first_id", acc_id[0], 0);
    chk("tie1_spacing", acc_cyc[1] - acc_cyc[0], 4);
    drain();

    // Single req0 add with carry: 3+5+1.
    post(0, mk(0,0,0,1,3'd2,3'd5,3'd3), 6'd9, 1'b0, 3);
    run_accept();
    drain();

    // Tie after req0 was served last: req1 wins this time.
    acc_id.delete(); acc_cyc.delete();
    post(0, mk(0,0,0,0,3'd2,3'd7,3'd7), 6'd14, 1'b0, 3);
    post(1, mk(0,0,0,0,3'd1,3'd3,3'd5), 6'd6, 1'b0, 3);
    run_accept();
    chk("tie2_first_id", acc_id[0], 1);
    drain();

    // req1 alone, 7*7; response fields hold afterwards.
    post(1, mk(0,0,0,0,3'd3,3'd7,3'd7), 6'h31, 1'b0, 3);
    run_accept();
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_data", int'(rsp_data), 49);
    chk("hold_id", int'(rsp_id), 1);

    // Local rejects: ALSU pins must not move.
    pins_before = pins();
    post(0, mk(0,0,0,0,3'd5,3'd1,3'd1), 6'd0, 1'b1, 1);
    run_accept();
    drain();
    chk("reject_op5_pins", int'(pins()), int'(pins_before));
    post(0, mk(0,0,0,0,3'd4,3'd2,3'd2), 6'd0, 1'b1, 1);
    run_accept();
    drain();
    post(0, mk(0,1,0,0,3'd2,3'd1,3'd1), 6'd0, 1'b1, 1);
    run_accept();
    drain();
    post(1, mk(1,0,0,0,3'd3,3'd1,3'd1), 6'd0, 1'b1, 1);
    run_accept();
    drain();
    chk("reject_red_pins", int'(pins()), int'(pins_before));

    // Legal reductions.
    post(0, mk(0,1,0,0,3'd0,3'd0,3'd7), 6'd1, 1'b0, 3);
    run_accept();
    drain();
    post(1, mk(1,0,0,0,3'd1,3'd4,3'd0), 6'd1, 1'b0, 3);
    run_accept();
    drain();

    // LEDS nonzero at sample reports an error alongside the data.
    inject_leds = 1'b1;
    post(1, mk(0,0,0,0,3'd2,3'd1,3'd1), 6'd2, 1'b1, 3);
    run_accept();
    drain();
    inject_leds = 1'b0;

    // Reset while busy: no response, outputs cleared, next tie goes to req0.
    post(1, mk(0,0,0,0,3'd3,3'd3,3'd3), 6'd9, 1'b0, 3);
    run_accept();
    @(posedge clk); #3;
    rst = 1'b1;
    sb.delete();
    #1;
    chk_all_zero("async_reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_all_zero("post_reset_quiet");
    acc_id.delete(); acc_cyc.delete();
    post(0, mk(0,0,0,0,3'd2,3'd2,3'd1), 6'd3, 1'b0, 3);
    post(1, mk(0,0,0,0,3'd2,3'd2,3'd2), 6'd4, 1'b0, 3);
    run_accept();
    chk("tie3_first_id", acc_id[0], 0);
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
